// File: rtl/uart_pkg.sv
// Shared definitions for the serial transmit path: default byte width,
// arbiter state encoding and a constant-evaluable clog2.
package uart_pkg;

  localparam int N_BIT_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    WAIT_DONE = 2'b01,
    HOLD      = 2'b10
  } arb_state_t;

  function automatic int clog2(input int value);
    int result;
    int rest;
    result = 0;
    rest   = value - 1;
    while (rest > 0) begin
      result++;
      rest = rest >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority encoder: first asserted request at or
// after ptr, wrapping from N_REQ-1 back to 0.
module rr_pick
  import uart_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]        req,
  input  logic [clog2(N_REQ)-1:0] ptr,
  output logic                    valid,
  output logic [clog2(N_REQ)-1:0] index
);

  localparam int ID_W = clog2(N_REQ);

  always_comb begin
    valid = 1'b0;
    index = '0;
    for (int k = 0; k < N_REQ; k++) begin
      int slot;
      slot = (int'(ptr) + k) % N_REQ;
      if (!valid && req[slot]) begin
        valid = 1'b1;
        index = ID_W'(slot);
      end
    end
  end

endmodule

// File: rtl/tx_arbiter.sv
// Round-robin arbiter sharing one serial transmitter between N_REQ byte
// producers, with per-message grant locking guarded by an idle timeout.
module tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_BIT        = N_BIT_DEFAULT,
  parameter int N_REQ        = 4,
  parameter int HOLD_TIMEOUT = 1024
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        req_last,
  input  logic [N_REQ*N_BIT-1:0]  req_data,
  output logic [N_REQ-1:0]        ack,
  output logic [clog2(N_REQ)-1:0] grant_id,
  output logic                    busy,
  output logic                    tx_start,
  output logic [N_BIT-1:0]        tx_din,
  input  logic                    tx_done
);

  localparam int ID_W  = clog2(N_REQ);
  localparam int CNT_W = (HOLD_TIMEOUT > 1) ? clog2(HOLD_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_TIMEOUT - 1);
  localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(N_REQ - 1);

  arb_state_t        state, state_n;
  logic              lock, lock_n;
  logic [ID_W-1:0]   ptr, ptr_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [N_REQ-1:0]  ack_n;
  logic              start_n;
  logic [N_BIT-1:0]  din_n;
  logic [ID_W-1:0]   gid_n;
  logic              busy_n;
  logic              grant;
  logic [ID_W-1:0]   sel;
  logic              pick_valid;
  logic [ID_W-1:0]   pick_index;

  rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
    .req   (req),
    .ptr   (ptr),
    .valid (pick_valid),
    .index (pick_index)
  );

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
    state_n = state;
    lock_n  = lock;
    ptr_n   = ptr;
    cnt_n   = cnt;
    ack_n   = '0;
    start_n = 1'b0;
    din_n   = tx_din;
    gid_n   = grant_id;
    grant   = 1'b0;
    sel     = grant_id;

    case (state)
      IDLE: begin
        if (pick_valid) begin
          grant = 1'b1;
          sel   = pick_index;
          ptr_n = (pick_index == ID_LAST) ? '0 : pick_index + ID_W'(1);
        end
      end
      WAIT_DONE: begin
        if (tx_done) begin
          state_n = lock ? HOLD : IDLE;
          cnt_n   = '0;
        end
      end
      HOLD: begin
        // Only the locked requester may continue; the rr pointer stays put.
        if (req[grant_id]) begin
          grant = 1'b1;
        end else if (cnt == CNT_LAST) begin
          lock_n  = 1'b0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase

    if (grant) begin
      ack_n[sel] = 1'b1;
      start_n    = 1'b1;
      din_n      = req_data[int'(sel)*N_BIT +: N_BIT];
      gid_n      = sel;
      lock_n     = ~req_last[sel];
      state_n    = WAIT_DONE;
    end

    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
    if (reset) begin
      state    <= IDLE;
      lock     <= 1'b0;
      ptr      <= '0;
      cnt      <= '0;
      ack      <= '0;
      tx_start <= 1'b0;
      tx_din   <= '0;
      grant_id <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      lock     <= lock_n;
      ptr      <= ptr_n;
      cnt      <= cnt_n;
      ack      <= ack_n;
      tx_start <= start_n;
      tx_din   <= din_n;
      grant_id <= gid_n;
      busy     <= busy_n;
    end
  end

endmodule

// File: tb/tb_tx_arbiter.sv
// Self-checking bench for tx_arbiter: queue-based requesters, a frame-timed
// transmitter and an abstract grant/lock/timeout model checked every cycle.
module tb_tx_arbiter;

  localparam int N_REQ        = 4;
  localparam int N_BIT        = 8;
  localparam int HOLD_TIMEOUT = 16;
  localparam int FRAME        = 10;
  localparam int ID_W         = 2;

  typedef struct packed {
    logic [7:0] d;
    logic       last;
  } item_t;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [N_REQ-1:0]       req;
  logic [N_REQ-1:0]       req_last;
  logic [N_REQ*N_BIT-1:0] req_data;
  logic [N_REQ-1:0]       ack;
  logic [ID_W-1:0]        grant_id;
  logic                   busy;
  logic                   tx_start;
  logic [N_BIT-1:0]       tx_din;
  logic                   tx_done;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  item_t q [N_REQ][$];
  int          grant_log[$];
  logic [7:0]  data_log[$];

  // Reference model state (abstract: pointer, lock owner, hold timer).
  int         m_ptr;
  bit         m_lock;
  int         m_lock_id;
  bit         m_hold;
  int         m_hold_t;
  bit         m_tx_busy;
  logic [7:0] m_din;
  bit         was_idle;
  bit         done_pending;
  int         tx_cnt;

  tx_arbiter #(.N_BIT(N_BIT), .N_REQ(N_REQ), .HOLD_TIMEOUT(HOLD_TIMEOUT)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .req_last (req_last),
    .req_data (req_data),
    .ack      (ack),
    .grant_id (grant_id),
    .busy     (busy),
    .tx_start (tx_start),
    .tx_din   (tx_din),
    .tx_done  (tx_done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  function automatic bit all_empty();
    for (int i = 0; i < N_REQ; i++)
      if (q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drive_reqs();
    for (int i = 0; i < N_REQ; i++) begin
      req[i]      = (q[i].size() != 0);
      req_last[i] = (q[i].size() != 0) ? q[i][0].last : 1'b0;
      req_data[i*N_BIT +: N_BIT] = (q[i].size() != 0) ? q[i][0].d : 8'h00;
    end
  endtask

  // One clock: observe outputs at the falling edge, advance the model,
  // then update transmitter and requester stimulus.
  task automatic step();
    bit               was_hold;
    int               exp_id;
    logic [N_REQ-1:0] req_s;
    logic [N_REQ-1:0] exp_ack;
    @(negedge clk);
    cyc++;
    was_hold = m_hold;
    req_s    = req;

    if (m_hold && !tx_start) begin
      m_hold_t++;
      if (m_hold_t == HOLD_TIMEOUT) begin
        m_hold = 1'b0;
        m_lock = 1'b0;
      end
    end
    if (done_pending && m_tx_busy) begin
      m_tx_busy = 1'b0;
      if (m_lock) begin
        m_hold   = 1'b1;
        m_hold_t = 0;
      end
    end

    if (tx_start) begin
      vectors++;
      if (!(was_idle || was_hold)) begin
        miscompares++;
        $display("FAIL unexpected_start: got tx_start=1 at cycle %0d, required 0 (byte outstanding)", cyc);
      end
      exp_id = -1;
      if (was_hold) begin
        if (req_s[m_lock_id]) exp_id = m_lock_id;
      end else begin
        for (int k = 0; k < N_REQ; k++)
          if (exp_id < 0 && req_s[(m_ptr + k) % N_REQ]) exp_id = (m_ptr + k) % N_REQ;
      end
      vectors++;
      if (exp_id < 0) begin
        miscompares++;
        $display("FAIL start_no_req: got tx_start=1 at cycle %0d, required 0 (no eligible request %b)", cyc, req_s);
      end else begin
        exp_ack = '0;
        exp_ack[exp_id] = 1'b1;
        vectors++;
        if (grant_id !== ID_W'(exp_id)) begin
          miscompares++;
          $display("FAIL grant_id: got %0d, required %0d (cycle %0d)", grant_id, exp_id, cyc);
        end
        vectors++;
        if (ack !== exp_ack) begin
          miscompares++;
          $display("FAIL ack: got %b, required %b (cycle %0d)", ack, exp_ack, cyc);
        end
        vectors++;
        if (tx_din !== q[exp_id][0].d) begin
          miscompares++;
          $display("FAIL tx_din: got %h, required %h (cycle %0d)", tx_din, q[exp_id][0].d, cyc);
        end
        if (!was_hold) m_ptr = (exp_id + 1) % N_REQ;
        m_lock    = !q[exp_id][0].last;
        m_lock_id = exp_id;
        m_din     = q[exp_id][0].d;
        grant_log.push_back(int'(grant_id));
        data_log.push_back(tx_din);
      end
      m_hold    = 1'b0;
      m_tx_busy = 1'b1;
    end else begin
      vectors++;
      if (ack !== '0) begin
        miscompares++;
        $display("FAIL ack_without_start: got %b, required 0000 (cycle %0d)", ack, cyc);
      end
      vectors++;
      if ((was_idle && req_s != '0) || (was_hold && req_s[m_lock_id])) begin
        miscompares++;
        $display("FAIL missed_grant: got tx_start=0, required 1 (req %b, cycle %0d)", req_s, cyc);
      end
    end

    vectors++;
    if (busy !== (m_tx_busy || m_hold)) begin
      miscompares++;
      $display("FAIL busy: got %b, required %b (cycle %0d)", busy, (m_tx_busy || m_hold), cyc);
    end
    if (m_tx_busy) begin
      vectors++;
      if (tx_din !== m_din) begin
        miscompares++;
        $display("FAIL tx_din_stable: got %h, required %h (cycle %0d)", tx_din, m_din, cyc);
      end
    end
    was_idle = !m_tx_busy && !m_hold;

    tx_done = 1'b0;
    if (tx_start) begin
      tx_cnt = FRAME;
    end else if (tx_cnt > 0) begin
      tx_cnt--;
      if (tx_cnt == 0) tx_done = 1'b1;
    end
    done_pending = tx_done;

    for (int i = 0; i < N_REQ; i++)
      if (ack[i] && q[i].size() != 0) void'(q[i].pop_front());
    drive_reqs();
  endtask

  task automatic run_until_idle(input int budget);
    int n;
    n = 0;
    while (!(all_empty() && was_idle && tx_cnt == 0 && !done_pending)) begin
      if (n >= budget) begin
        vectors++;
        miscompares++;
        $display("FAIL drain_timeout: still busy after %0d cycles, required idle", budget);
        return;
      end
      step();
      n++;
    end
  endtask

  task automatic wait_start(input int budget);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (tx_start !== 1'b1 && n < budget);
    vectors++;
    if (tx_start !== 1'b1) begin
      miscompares++;
      $display("FAIL start_timeout: got no tx_start within %0d cycles, required one", budget);
    end
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    tx_done      = 1'b0;
    done_pending = 1'b0;
    tx_cnt       = 0;
    @(negedge clk);
    vectors += 5;
    if (busy !== 1'b0)     begin miscompares++; $display("FAIL reset_busy: got %b, required 0", busy); end
    if (ack !== '0)        begin miscompares++; $display("FAIL reset_ack: got %b, required 0000", ack); end
    if (tx_start !== 1'b0) begin miscompares++; $display("FAIL reset_tx_start: got %b, required 0", tx_start); end
    if (grant_id !== '0)   begin miscompares++; $display("FAIL reset_grant_id: got %0d, required 0", grant_id); end
    if (tx_din !== '0)     begin miscompares++; $display("FAIL reset_tx_din: got %h, required 00", tx_din); end
    reset     = 1'b0;
    m_ptr     = 0;
    m_lock    = 1'b0;
    m_lock_id = 0;
    m_hold    = 1'b0;
    m_hold_t  = 0;
    m_tx_busy = 1'b0;
    m_din     = 8'h00;
    was_idle  = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    q[0].push_back(item_t'{d: 8'hA5, last: 1'b1});
    drive_reqs();
    step();
    vectors++;
    if (tx_start !== 1'b1 || ack !== 4'b0001 || tx_din !== 8'hA5) begin
      miscompares++;
      $display("FAIL single: got start=%b ack=%b din=%h, required 1 0001 a5", tx_start, ack, tx_din);
    end
    run_until_idle(100);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL single_busy_end: got %b, required 0", busy);
    end
  endtask

  task automatic test_round_robin();
    int exp_order[5];
    exp_order = '{0, 1, 2, 3, 0};
    do_reset();
    for (int i = 0; i < N_REQ; i++)
      for (int b = 0; b < 2; b++)
        q[i].push_back(item_t'{d: 8'($urandom), last: 1'b1});
    drive_reqs();
    grant_log.delete();
    run_until_idle(400);
    vectors++;
    if (grant_log.size() != 8) begin
      miscompares++;
      $display("FAIL rr_count: got %0d grants, required 8", grant_log.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        vectors++;
        if (grant_log[k] != exp_order[k]) begin
          miscompares++;
          $display("FAIL rr_order[%0d]: got %0d, required %0d", k, grant_log[k], exp_order[k]);
        end
      end
    end
  endtask

  task automatic test_message_lock();
    int         exp_ids[4];
    logic [7:0] exp_data[4];
    exp_ids  = '{1, 1, 1, 2};
    exp_data = '{8'h01, 8'h02, 8'h03, 8'h77};
    do_reset();
    q[1].push_back(item_t'{d: 8'h01, last: 1'b0});
    q[1].push_back(item_t'{d: 8'h02, last: 1'b0});
    q[1].push_back(item_t'{d: 8'h03, last: 1'b1});
    q[2].push_back(item_t'{d: 8'h77, last: 1'b1});
    drive_reqs();
    grant_log.delete();
    data_log.delete();
    run_until_idle(200);
    vectors++;
    if (grant_log.size() != 4) begin
      miscompares++;
      $display("FAIL lock_count: got %0d grants, required 4", grant_log.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        vectors++;
        if (grant_log[k] != exp_ids[k] || data_log[k] !== exp_data[k]) begin
          miscompares++;
          $display("FAIL lock_seq[%0d]: got id %0d data %h, required id %0d data %h",
                   k, grant_log[k], data_log[k], exp_ids[k], exp_data[k]);
        end
      end
    end
  endtask

  task automatic test_lock_timeout();
    int s0;
    do_reset();
    q[0].push_back(item_t'{d: 8'h3C, last: 1'b0});
    drive_reqs();
    wait_start(20);
    s0 = cyc;
    q[3].push_back(item_t'{d: 8'hC3, last: 1'b1});
    drive_reqs();
    wait_start(100);
    vectors++;
    if (cyc - s0 != FRAME + 18 || grant_id !== 2'd3 || tx_din !== 8'hC3) begin
      miscompares++;
      $display("FAIL timeout: got gap %0d id %0d din %h, required gap %0d id 3 din c3",
               cyc - s0, grant_id, tx_din, FRAME + 18);
    end
    run_until_idle(100);
  endtask

  task automatic test_reset_mid();
    do_reset();
    q[1].push_back(item_t'{d: 8'h11, last: 1'b0});
    q[1].push_back(item_t'{d: 8'h22, last: 1'b1});
    drive_reqs();
    wait_start(20);
    repeat (3) step();
    q[1].delete();
    q[2].push_back(item_t'{d: 8'h5A, last: 1'b1});
    drive_reqs();
    do_reset();
    step();
    vectors++;
    if (tx_start !== 1'b1 || grant_id !== 2'd2 || tx_din !== 8'h5A) begin
      miscompares++;
      $display("FAIL reset_mid: got start=%b id=%0d din=%h, required 1 2 5a", tx_start, grant_id, tx_din);
    end
    run_until_idle(100);
  endtask

  task automatic test_spurious_done();
    tx_done      = 1'b1;
    done_pending = 1'b1;
    step();
    step();
    vectors++;
    if (busy !== 1'b0 || ack !== '0 || tx_start !== 1'b0) begin
      miscompares++;
      $display("FAIL spurious_done: got busy=%b ack=%b start=%b, required 0 0000 0", busy, ack, tx_start);
    end
  endtask

  task automatic test_random();
    int n;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (q[i].size() == 0 && $urandom_range(0, 7) == 0) begin
          n = $urandom_range(1, 3);
          for (int b = 0; b < n; b++)
            q[i].push_back(item_t'{d: 8'($urandom), last: (b == n - 1)});
        end
      end
      drive_reqs();
      step();
    end
    run_until_idle(2000);
  endtask

  initial begin
    reset        = 1'b1;
    req          = '0;
    req_last     = '0;
    req_data     = '0;
    tx_done      = 1'b0;
    done_pending = 1'b0;
    tx_cnt       = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_message_lock();
    test_lock_timeout();
    test_reset_mid();
    test_spurious_done();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
